rom_loader: RTL and testbench

//   Boot sequencer for the Hack computer: holds the CPU in reset, receives a program image
//   as a byte stream (valid/ready), assembles big-endian 16-bit words and writes them into

---
 rtl/rom_loader_pkg.sv | 25 ++
 rtl/rom_loader_if.sv | 28 ++
 rtl/rom_loader_word_assembler.sv | 42 ++++
 rtl/rom_loader.sv | 198 +++++++++++++++++++
 tb/tb_rom_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the Hack boot loader.
//   - loader_state_t  : FSM state encoding used by rom_loader
//   - ROM_WORD_WIDTH  : width of one instruction ROM word
//   - IMAGE_BIG_ENDIAN: byte order of 16-bit words in the image stream
package rom_loader_pkg;

  localparam int ROM_WORD_WIDTH = 16;

  // Image words arrive high byte first.
  localparam bit IMAGE_BIG_ENDIAN = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COUNT_HI,
    ST_COUNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CSUM_HI,
    ST_CSUM_LO,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream and ROM write-port bundle for rom_loader.
//   byte_in/byte_valid/byte_ready : host byte link (valid/ready)
//   rom_write_addr/data/enable    : instruction ROM write port
// modport master: host side (drives bytes, observes ROM writes)
// modport slave : loader side
interface rom_loader_if #(
  parameter int ADDR_WIDTH = 15
);
  import rom_loader_pkg::*;

  logic [7:0]                byte_in;
  logic                      byte_valid;
  logic                      byte_ready;
  logic [ADDR_WIDTH-1:0]     rom_write_addr;
  logic [ROM_WORD_WIDTH-1:0] rom_write_data;
  logic                      rom_write_enable;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, rom_write_addr, rom_write_data, rom_write_enable
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, rom_write_addr, rom_write_data, rom_write_enable
  );

endinterface

// File: rtl/rom_loader_word_assembler.sv
// Pairs two stream bytes into one 16-bit image word.
//   clock, reset_n : clock / async active-low reset
//   clear          : drop any latched first byte (load restart)
//   byte_in        : current stream byte
//   accept_hi      : first byte of a word is being transferred
//   accept_lo      : second byte of a word is being transferred
//   word           : assembled word, valid while word_valid=1
//   word_valid     : second byte transferring this cycle
// The word is formed combinationally from the latched first byte and the
// byte currently on the link, so the FSM can act on it at the same edge
// that accepts the second byte.
module rom_loader_word_assembler
  import rom_loader_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [7:0]                byte_in,
  input  logic                      accept_hi,
  input  logic                      accept_lo,
  output logic [ROM_WORD_WIDTH-1:0] word,
  output logic                      word_valid
);

  logic [7:0] first_byte;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      first_byte <= 8'h00;
    end else if (clear) begin
      first_byte <= 8'h00;
    end else if (accept_hi) begin
      first_byte <= byte_in;
    end
  end

  always_comb begin
    word       = IMAGE_BIG_ENDIAN ? {first_byte, byte_in} : {byte_in, first_byte};
    word_valid = accept_lo;
  end

endmodule

// File: rtl/rom_loader.sv
// Boot sequencer for the Hack computer. Holds the CPU in reset, receives a
// program image over a valid/ready byte link (COUNT_HI, COUNT_LO, then N x
// DATA_HI, DATA_LO), writes the words into instruction ROM from address 0,
// then releases the CPU.
//   clock, reset_n : clock / async active-low reset
//   start          : 1-cycle pulse, begin or restart a load from any state
//   bus (slave)    : byte link and ROM write port, see rom_loader_if
//   cpu_reset      : 1 = CPU held in reset (registered)
//   busy           : load in progress
//   done           : image loaded, CPU running
//   error          : load failed, CPU stays held
// Optional feature: ROM_LOADER_CHECKSUM_EN adds CSUM_HI/CSUM_LO states that
// check a 16-bit mod-2**16 sum of all data words before releasing the CPU.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  rom_loader_if.slave bus,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned MAX_WORDS = 32'd1 << ADDR_WIDTH;

  loader_state_t             state;
  logic [15:0]               words_left;
  logic                      handshake;
  logic                      accept_hi;
  logic                      accept_lo;
  logic [ROM_WORD_WIDTH-1:0] word;
  logic                      word_valid;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [ROM_WORD_WIDTH-1:0] csum_acc;
`endif

  // A start pulse overrides any byte offered on the same edge.
  always_comb begin
    handshake = bus.byte_valid & bus.byte_ready & ~start;
    accept_hi = handshake & ((state == ST_COUNT_HI) | (state == ST_DATA_HI) |
                             (state == ST_CSUM_HI));
    accept_lo = handshake & ((state == ST_COUNT_LO) | (state == ST_DATA_LO) |
                             (state == ST_CSUM_LO));
  end

  rom_loader_word_assembler u_word_assembler (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (start),
    .byte_in    (bus.byte_in),
    .accept_hi  (accept_hi),
    .accept_lo  (accept_lo),
    .word       (word),
    .word_valid (word_valid)
  );

  // byte_ready and busy are updated together with the state so they line up
  // with it. cpu_reset and done follow the state with one cycle of lag: they
  // only change while already sitting in RUN, so cpu_reset can never drop
  // outside RUN and a start pulse raises it on the same edge that leaves RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= ST_IDLE;
      words_left           <= 16'd0;
      bus.byte_ready       <= 1'b0;
      bus.rom_write_addr   <= '0;
      bus.rom_write_data   <= '0;
      bus.rom_write_enable <= 1'b0;
      cpu_reset            <= 1'b1;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_acc             <= '0;
`endif
    end else if (start) begin
      // Partial ROM content and the last write data are intentionally kept.
      state                <= ST_COUNT_HI;
      words_left           <= 16'd0;
      bus.byte_ready       <= 1'b1;
      bus.rom_write_addr   <= '0;
      bus.rom_write_enable <= 1'b0;
      cpu_reset            <= 1'b1;
      busy                 <= 1'b1;
      done                 <= 1'b0;
      error                <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_acc             <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
        end

        ST_COUNT_HI: begin
          if (accept_hi) state <= ST_COUNT_LO;
        end

        ST_COUNT_LO: begin
          if (word_valid) begin
            words_left <= word;
            if (32'(word) > MAX_WORDS) begin
              state          <= ST_ERROR;
              bus.byte_ready <= 1'b0;
              busy           <= 1'b0;
              error          <= 1'b1;
            end else if (word == 16'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              state          <= ST_CSUM_HI;
`else
              state          <= ST_RUN;
              bus.byte_ready <= 1'b0;
              busy           <= 1'b0;
`endif
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end

        ST_DATA_HI: begin
          if (accept_hi) state <= ST_DATA_LO;
        end

        ST_DATA_LO: begin
          if (word_valid) begin
            state                <= ST_WRITE;
            bus.byte_ready       <= 1'b0;
            bus.rom_write_data   <= word;
            bus.rom_write_enable <= 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_acc             <= csum_acc + word;
`endif
          end
        end

        // The address advances after every write, so a full 2**ADDR_WIDTH
        // image leaves it wrapped to 0; nothing reads it in RUN.
        ST_WRITE: begin
          bus.rom_write_enable <= 1'b0;
          bus.rom_write_addr   <= bus.rom_write_addr + ADDR_WIDTH'(1);
          words_left           <= words_left - 16'd1;
          if (words_left == 16'd1) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            state          <= ST_CSUM_HI;
            bus.byte_ready <= 1'b1;
`else
            state          <= ST_RUN;
            busy           <= 1'b0;
`endif
          end else begin
            state          <= ST_DATA_HI;
            bus.byte_ready <= 1'b1;
          end
        end

`ifdef ROM_LOADER_CHECKSUM_EN
        ST_CSUM_HI: begin
          if (accept_hi) state <= ST_CSUM_LO;
        end

        ST_CSUM_LO: begin
          if (word_valid) begin
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            if (word == csum_acc) begin
              state <= ST_RUN;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif

        ST_RUN: begin
          cpu_reset <= 1'b0;
          done      <= 1'b1;
        end

        ST_ERROR: begin
        end

        default: begin
          state          <= ST_IDLE;
          bus.byte_ready <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader, built with ADDR_WIDTH=4 so the oversize
// and full-depth cases stay short. Works with and without
// ROM_LOADER_CHECKSUM_EN; the image sender appends a checksum when enabled.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int AW = 4;
`ifdef ROM_LOADER_CHECKSUM_EN
  localparam int RELEASE_EDGES = 1;
`else
  localparam int RELEASE_EDGES = 2;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic cpu_reset, busy, done, error;

  rom_loader_if #(.ADDR_WIDTH(AW)) bus ();

  rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .bus       (bus.slave),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int hold_violations = 0;
  bit hold_expected = 1'b0;

  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];
  logic [15:0]   img_words[$];

  // Record every ROM write strobe; a strobe held for two cycles shows up twice.
  always @(negedge clock) begin
    if (bus.rom_write_enable === 1'b1) begin
      wr_addr_q.push_back(bus.rom_write_addr);
      wr_data_q.push_back(bus.rom_write_data);
    end
    if (hold_expected && cpu_reset !== 1'b1) hold_violations++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit accepted = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      @(posedge clock); #1;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int c = 0; c < 50 && !accepted; c++) begin
      if (bus.byte_ready === 1'b1) accepted = 1'b1;
      @(posedge clock); #1;
    end
    bus.byte_valid = 1'b0;
    vectors++;
    if (!accepted) begin
      miscompares++;
      $display("[TB] FAIL byte_accept: byte %h not accepted within 50 cycles, ready=%b", b, bus.byte_ready);
    end
  endtask

  task automatic send_image(input logic [15:0] n, input int max_gap, input logic [15:0] csum_delta);
    logic [15:0] sum;
    logic [15:0] w;
    sum = 16'h0000;
    send_byte(n[15:8], $urandom_range(0, max_gap));
    send_byte(n[7:0], $urandom_range(0, max_gap));
    foreach (img_words[i]) begin
      w = img_words[i];
      send_byte(w[15:8], $urandom_range(0, max_gap));
      send_byte(w[7:0], $urandom_range(0, max_gap));
      sum = sum + w;
    end
    sum = sum + csum_delta;
`ifdef ROM_LOADER_CHECKSUM_EN
    send_byte(sum[15:8], $urandom_range(0, max_gap));
    send_byte(sum[7:0], $urandom_range(0, max_gap));
`endif
  endtask

  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_release(output int edges);
    edges = 0;
    while (cpu_reset !== 1'b0 && edges < 20) begin
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    #12 reset_n = 1'b0;
    #2;
    vectors++;
    if ({cpu_reset, bus.byte_ready, bus.rom_write_enable, busy, done, error} !== 6'b100000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 100000",
               {cpu_reset, bus.byte_ready, bus.rom_write_enable, busy, done, error});
    end
    vectors++;
    if (bus.rom_write_addr !== 4'h0 || bus.rom_write_data !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_bus: addr=%h data=%h expected 0/0000", bus.rom_write_addr, bus.rom_write_data);
    end
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({cpu_reset, bus.byte_ready, busy, done} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL idle_hold: got %b expected 1000", {cpu_reset, bus.byte_ready, busy, done});
    end
  endtask

  task automatic test_basic_load(input int max_gap);
    int edges;
    wr_addr_q.delete(); wr_data_q.delete();
    img_words = '{16'h1234, 16'hABCD};
    pulse_start();
    vectors++;
    if ({busy, cpu_reset, done, error, bus.byte_ready} !== 5'b11001) begin
      miscompares++;
      $display("[TB] FAIL start_flags: got %b expected 11001", {busy, cpu_reset, done, error, bus.byte_ready});
    end
    hold_violations = 0;
    hold_expected = 1'b1;
    send_image(16'd2, max_gap, 16'h0000);
    hold_expected = 1'b0;
    wait_release(edges);
    vectors++;
    if (edges != RELEASE_EDGES) begin
      miscompares++;
      $display("[TB] FAIL release_latency(gap %0d): got %0d edges expected %0d", max_gap, edges, RELEASE_EDGES);
    end
    vectors++;
    if ({done, busy, error, cpu_reset, hold_violations == 0} !== 5'b10001) begin
      miscompares++;
      $display("[TB] FAIL run_flags(gap %0d): got %b expected 10001", max_gap,
               {done, busy, error, cpu_reset, hold_violations == 0});
    end
    vectors++;
    if (wr_data_q.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL write_count(gap %0d): got %0d expected 2", max_gap, wr_data_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if ({wr_addr_q[i], wr_data_q[i]} !== {AW'(i), img_words[i]}) begin
          miscompares++;
          $display("[TB] FAIL write_%0d(gap %0d): got %h@%h expected %h@%h", i, max_gap,
                   wr_data_q[i], wr_addr_q[i], img_words[i], AW'(i));
        end
      end
    end
  endtask

  task automatic test_zero_length();
    int edges;
    wr_addr_q.delete(); wr_data_q.delete();
    img_words.delete();
    pulse_start();
    send_image(16'd0, 0, 16'h0000);
    wait_release(edges);
    vectors++;
    if (edges != 1 || done !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_len_run: edges=%0d done=%b error=%b expected 1/1/0", edges, done, error);
    end
    vectors++;
    if (wr_data_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL zero_len_writes: got %0d writes expected 0", wr_data_q.size());
    end
  endtask

  task automatic test_full_depth();
    int edges;
    wr_addr_q.delete(); wr_data_q.delete();
    img_words.delete();
    for (int i = 0; i < 16; i++) img_words.push_back(16'(i * 16'h1111 + 16'h0007));
    pulse_start();
    send_image(16'd16, 1, 16'h0000);
    wait_release(edges);
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || bus.rom_write_addr !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL full_depth_run: done=%b error=%b addr=%h expected 1/0/0", done, error, bus.rom_write_addr);
    end
    vectors++;
    if (wr_data_q.size() != 16) begin
      miscompares++;
      $display("[TB] FAIL full_depth_count: got %0d writes expected 16", wr_data_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if ({wr_addr_q[i], wr_data_q[i]} !== {AW'(i), img_words[i]}) begin
          miscompares++;
          $display("[TB] FAIL full_depth_write_%0d: got %h@%h expected %h@%h", i,
                   wr_data_q[i], wr_addr_q[i], img_words[i], AW'(i));
        end
      end
    end
  endtask

  task automatic test_oversize();
    int edges;
    bit saw_ready = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    vectors++;
    if ({error, cpu_reset, bus.byte_ready, busy, done} !== 5'b11000) begin
      miscompares++;
      $display("[TB] FAIL oversize_error: got %b expected 11000", {error, cpu_reset, bus.byte_ready, busy, done});
    end
    bus.byte_in = 8'h55;
    bus.byte_valid = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
      if (bus.byte_ready !== 1'b0) saw_ready = 1'b1;
    end
    bus.byte_valid = 1'b0;
    vectors++;
    if (saw_ready || error !== 1'b1 || wr_data_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL error_sticky: ready_seen=%b error=%b writes=%0d expected 0/1/0",
               saw_ready, error, wr_data_q.size());
    end
    img_words = '{16'hBEEF};
    pulse_start();
    vectors++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL error_clear: error=%b busy=%b expected 0/1", error, busy);
    end
    send_image(16'd1, 1, 16'h0000);
    wait_release(edges);
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || wr_data_q.size() != 1 || wr_data_q[0] !== 16'hBEEF || wr_addr_q[0] !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL recover_load: done=%b error=%b writes=%0d expected done=1 error=0 one write BEEF@0",
               done, error, wr_data_q.size());
    end
  endtask

  task automatic test_restart_mid_load();
    int edges;
    logic [AW-1:0] exp_addr[3];
    logic [15:0]   exp_data[3];
    exp_addr = '{4'h0, 4'h0, 4'h1};
    exp_data = '{16'h1111, 16'hCAFE, 16'hF00D};
    wr_addr_q.delete(); wr_data_q.delete();
    pulse_start();
    hold_violations = 0;
    hold_expected = 1'b1;
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    repeat (2) @(posedge clock);
    #1;
    // Start and an offered byte on the same edge: the byte must be dropped.
    bus.byte_in = 8'h77;
    bus.byte_valid = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    vectors++;
    if ({busy, cpu_reset, done, bus.byte_ready} !== 4'b1101 || bus.rom_write_addr !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL restart_flags: got %b addr=%h expected 1101 addr=0",
               {busy, cpu_reset, done, bus.byte_ready}, bus.rom_write_addr);
    end
    img_words = '{16'hCAFE, 16'hF00D};
    send_image(16'd2, 1, 16'h0000);
    hold_expected = 1'b0;
    wait_release(edges);
    vectors++;
    if (done !== 1'b1 || error !== 1'b0 || hold_violations != 0 || edges != RELEASE_EDGES) begin
      miscompares++;
      $display("[TB] FAIL restart_run: done=%b error=%b hold_violations=%0d edges=%0d expected 1/0/0/%0d",
               done, error, hold_violations, edges, RELEASE_EDGES);
    end
    vectors++;
    if (wr_data_q.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL restart_count: got %0d writes expected 3", wr_data_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if ({wr_addr_q[i], wr_data_q[i]} !== {exp_addr[i], exp_data[i]}) begin
          miscompares++;
          $display("[TB] FAIL restart_write_%0d: got %h@%h expected %h@%h", i,
                   wr_data_q[i], wr_addr_q[i], exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

`ifdef ROM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int edges;
    img_words = '{16'h8000, 16'h8001};
    pulse_start();
    send_image(16'd2, 0, 16'h0000);
    wait_release(edges);
    vectors++;
    if (done !== 1'b1 || error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL csum_good: done=%b error=%b expected 1/0", done, error);
    end
    pulse_start();
    send_image(16'd2, 0, 16'h0001);
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({error, cpu_reset, done, bus.byte_ready} !== 4'b1100) begin
      miscompares++;
      $display("[TB] FAIL csum_bad: got %b expected 1100", {error, cpu_reset, done, bus.byte_ready});
    end
  endtask
`endif

  initial begin
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    test_reset();
    test_basic_load(0);
    test_basic_load(3);
    test_zero_length();
    test_full_depth();
    test_oversize();
    test_restart_mid_load();
`ifdef ROM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
